// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MERGE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic [3:0] WSTRB_FULL = 4'b1111;
   localparam logic [3:0] WSTRB_NONE = 4'b0000;

   localparam logic SIDE_INST = 1'b0;
   localparam logic SIDE_DATA = 1'b1;

endpackage

// File: rtl/wstrb_merge.sv
// Bytewise merge: each set strobe bit takes that byte from new_i, else from old_i.
module wstrb_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   input  logic [3:0]  wstrb_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int b = 0; b < 4; b++) begin
         if (wstrb_i[b]) merged_o[b*8 +: 8] = new_i[b*8 +: 8];
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one async-read/sync-write RAM between fetch and load/store.
// Partial writes take a read-modify-write detour through MERGE.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  inst_req,
   input  logic [31:0]           inst_addr,
   output logic                  inst_addr_ok,
   output logic                  inst_data_ok,
   output logic [31:0]           inst_rdata,
   input  logic                  data_req,
   input  logic                  data_wr,
   input  logic [3:0]            data_wstrb,
   input  logic [31:0]           data_addr,
   input  logic [31:0]           data_wdata,
   output logic                  data_addr_ok,
   output logic                  data_data_ok,
   output logic [31:0]           data_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_spo
);

   state_e                  state_q, state_d;
   logic                    last_grant_q;
   logic                    side_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   ram_a_q;
   logic [31:0]             merge_q;
   logic [31:0]             inst_rdata_q;
   logic [31:0]             data_rdata_q;
   logic [31:0]             merged;

   logic                    idle;
   logic                    grant_inst;
   logic                    grant_data;
   logic                    accept;
   logic                    full_wr;
   logic                    partial_wr;
   logic [ADDR_WIDTH-1:0]   req_word;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^{inst_addr, data_addr};

   // Gating with resetn keeps every handshake low while reset is held.
   always_comb begin
      idle       = (state_q == IDLE) && resetn;
      grant_inst = idle && inst_req && (!data_req || (last_grant_q == SIDE_DATA));
      grant_data = idle && data_req && (!inst_req || (last_grant_q == SIDE_INST));
      accept     = grant_inst || grant_data;
      req_word   = grant_inst ? inst_addr[ADDR_WIDTH+1:2] : data_addr[ADDR_WIDTH+1:2];
      full_wr    = grant_data && data_wr && (data_wstrb == WSTRB_FULL);
      partial_wr = grant_data && data_wr && (data_wstrb != WSTRB_FULL)
                   && (data_wstrb != WSTRB_NONE);
   end

   wstrb_merge u_merge (
      .old_i   (ram_spo),
      .new_i   (data_wdata),
      .wstrb_i (data_wstrb),
      .merged_o(merged)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (partial_wr)  state_d = MERGE;
            else if (accept) state_d = RESP;
         end
         MERGE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      inst_addr_ok = grant_inst;
      data_addr_ok = grant_data;
      inst_data_ok = (state_q == RESP) && (side_q == SIDE_INST);
      data_data_ok = (state_q == RESP) && (side_q == SIDE_DATA);
      ram_we       = full_wr || (state_q == MERGE);
      ram_d        = (state_q == MERGE) ? merge_q : data_wdata;
      if (accept)                 ram_a = req_word;
      else if (state_q == MERGE)  ram_a = addr_q;
      else                        ram_a = ram_a_q;
      inst_rdata   = inst_rdata_q;
      data_rdata   = data_rdata_q;
   end

   // Read data is captured at the accept edge since the RAM reads asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant_q <= SIDE_DATA;
         side_q       <= SIDE_INST;
         addr_q       <= '0;
         ram_a_q      <= '0;
         merge_q      <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         ram_a_q <= ram_a;
         if (accept) begin
            last_grant_q <= grant_data;
            side_q       <= grant_data;
            addr_q       <= req_word;
         end
         if (grant_inst)              inst_rdata_q <= ram_spo;
         if (grant_data && !data_wr)  data_rdata_q <= ram_spo;
         if (partial_wr)              merge_q      <= merged;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        ram_we;
   logic [15:0] ram_a;
   logic [31:0] ram_d;
   logic [31:0] ram_spo;

   logic [31:0] mem [0:65535];
   logic        pre_we;
   logic [15:0] pre_a;
   logic [31:0] pre_d;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign ram_spo = mem[ram_a];
   always @(posedge clk) begin
      if (ram_we)      mem[ram_a] <= ram_d;
      else if (pre_we) mem[pre_a] <= pre_d;
   end

   ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
   );

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_a = a; pre_d = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
      @(negedge clk); #1;
      checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_inst_aok got=%0b exp=0", inst_addr_ok); end
      checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_data_aok got=%0b exp=0", data_addr_ok); end
      checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL rst_inst_dok got=%0b exp=0", inst_data_ok); end
      checks++; if (data_data_ok !== 1'b0) begin failures++; $display("FAIL rst_data_dok got=%0b exp=0", data_data_ok); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%0b exp=0", ram_we); end
      checks++; if (ram_a !== 16'h0) begin failures++; $display("FAIL rst_ram_a got=%h exp=0000", ram_a); end
      checks++; if (inst_rdata !== 32'h0) begin failures++; $display("FAIL rst_inst_rdata got=%h exp=0", inst_rdata); end
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL rst_data_rdata got=%h exp=0", data_rdata); end
      inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
   endtask

   task automatic test_arbitration();
      @(negedge clk);
      resetn = 1'b1;
      inst_req = 1'b1; inst_addr = 32'h8;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h4;
      #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL arb1_inst_aok got=%0b exp=1", inst_addr_ok); end
      checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL arb1_data_aok got=%0b exp=0", data_addr_ok); end
      checks++; if (ram_a !== 16'd2) begin failures++; $display("FAIL arb1_ram_a got=%h exp=0002", ram_a); end
      @(negedge clk); #1;
      checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL arb1_inst_dok got=%0b exp=1", inst_data_ok); end
      checks++; if (inst_rdata !== 32'h11223344) begin failures++; $display("FAIL arb1_inst_rdata got=%h exp=11223344", inst_rdata); end
      checks++; if ((inst_addr_ok | data_addr_ok) !== 1'b0) begin failures++; $display("FAIL arb_resp_aok got=%0b/%0b exp=0/0", inst_addr_ok, data_addr_ok); end
      @(negedge clk); #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL arb2_data_aok got=%0b exp=1", data_addr_ok); end
      checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL arb2_inst_aok got=%0b exp=0", inst_addr_ok); end
      checks++; if (ram_a !== 16'd1) begin failures++; $display("FAIL arb2_ram_a got=%h exp=0001", ram_a); end
      @(negedge clk); #1;
      checks++; if (data_data_ok !== 1'b1) begin failures++; $display("FAIL arb2_data_dok got=%0b exp=1", data_data_ok); end
      checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL arb2_inst_dok got=%0b exp=0", inst_data_ok); end
      checks++; if (data_rdata !== 32'h02800c0c) begin failures++; $display("FAIL arb2_data_rdata got=%h exp=02800c0c", data_rdata); end
      @(negedge clk); #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL arb3_inst_aok got=%0b exp=1", inst_addr_ok); end
      checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL arb3_data_aok got=%0b exp=0", data_addr_ok); end
      @(negedge clk);
      inst_req = 1'b0; data_req = 1'b0;
      #1;
      checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL arb3_inst_dok got=%0b exp=1", inst_data_ok); end
      @(negedge clk);
   endtask

   task automatic test_inst_read();
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h1c000004;
      #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL ird_aok got=%0b exp=1", inst_addr_ok); end
      checks++; if (ram_a !== 16'd1) begin failures++; $display("FAIL ird_ram_a got=%h exp=0001", ram_a); end
      checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL ird_dok_early got=%0b exp=0", inst_data_ok); end
      @(negedge clk);
      inst_req = 1'b0;
      #1;
      checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL ird_dok got=%0b exp=1", inst_data_ok); end
      checks++; if (inst_rdata !== 32'h02800c0c) begin failures++; $display("FAIL ird_rdata got=%h exp=02800c0c", inst_rdata); end
      @(negedge clk); #1;
      checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL ird_dok_pulse got=%0b exp=0", inst_data_ok); end
   endtask

   task automatic test_partial_write();
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3; data_addr = 32'h8; data_wdata = 32'hAABBCCDD;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL pw_aok got=%0b exp=1", data_addr_ok); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL pw_we_accept got=%0b exp=0", ram_we); end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL pw_we_merge got=%0b exp=1", ram_we); end
      checks++; if (ram_a !== 16'd2) begin failures++; $display("FAIL pw_ram_a got=%h exp=0002", ram_a); end
      checks++; if (ram_d !== 32'h1122CCDD) begin failures++; $display("FAIL pw_ram_d got=%h exp=1122ccdd", ram_d); end
      checks++; if (data_data_ok !== 1'b0) begin failures++; $display("FAIL pw_dok_early got=%0b exp=0", data_data_ok); end
      @(negedge clk); #1;
      checks++; if (data_data_ok !== 1'b1) begin failures++; $display("FAIL pw_dok got=%0b exp=1", data_data_ok); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL pw_we_resp got=%0b exp=0", ram_we); end
      checks++; if (mem[2] !== 32'h1122CCDD) begin failures++; $display("FAIL pw_mem got=%h exp=1122ccdd", mem[2]); end
      checks++; if (data_rdata !== 32'h02800c0c) begin failures++; $display("FAIL pw_rdata_hold got=%h exp=02800c0c", data_rdata); end
      @(negedge clk); #1;
      checks++; if (data_data_ok !== 1'b0) begin failures++; $display("FAIL pw_dok_pulse got=%0b exp=0", data_data_ok); end
   endtask

   task automatic test_full_write();
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h10; data_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL fw_aok got=%0b exp=1", data_addr_ok); end
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL fw_we got=%0b exp=1", ram_we); end
      checks++; if (ram_a !== 16'd4) begin failures++; $display("FAIL fw_ram_a got=%h exp=0004", ram_a); end
      checks++; if (ram_d !== 32'hDEADBEEF) begin failures++; $display("FAIL fw_ram_d got=%h exp=deadbeef", ram_d); end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      checks++; if (data_data_ok !== 1'b1) begin failures++; $display("FAIL fw_dok got=%0b exp=1", data_data_ok); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL fw_we_resp got=%0b exp=0", ram_we); end
      checks++; if (ram_a !== 16'd4) begin failures++; $display("FAIL fw_ram_a_hold got=%h exp=0004", ram_a); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL fw_mem got=%h exp=deadbeef", mem[4]); end
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h10;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL rd10_aok got=%0b exp=1", data_addr_ok); end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      checks++; if (data_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd10_rdata got=%h exp=deadbeef", data_rdata); end
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h0; data_addr = 32'h10; data_wdata = 32'h12345678;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL zw_aok got=%0b exp=1", data_addr_ok); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL zw_we got=%0b exp=0", ram_we); end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      checks++; if (data_data_ok !== 1'b1) begin failures++; $display("FAIL zw_dok got=%0b exp=1", data_data_ok); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_mem got=%h exp=deadbeef", mem[4]); end
      checks++; if (data_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_rdata_hold got=%h exp=deadbeef", data_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_merge();
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hC; data_addr = 32'h8; data_wdata = 32'h55667788;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL rm_aok got=%0b exp=1", data_addr_ok); end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL rm_we_merge got=%0b exp=1", ram_we); end
      resetn = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rm_we_rst got=%0b exp=0", ram_we); end
      @(negedge clk); #1;
      checks++; if (mem[2] !== 32'h1122CCDD) begin failures++; $display("FAIL rm_mem got=%h exp=1122ccdd", mem[2]); end
      checks++; if (data_data_ok !== 1'b0) begin failures++; $display("FAIL rm_dok_rst got=%0b exp=0", data_data_ok); end
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL rm_rdata_clr got=%h exp=0", data_rdata); end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rm_we_rel got=%0b exp=0", ram_we); end
      @(negedge clk); #1;
      checks++; if (data_data_ok !== 1'b0) begin failures++; $display("FAIL rm_dok_rel got=%0b exp=0", data_data_ok); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rm_we_rel2 got=%0b exp=0", ram_we); end
      checks++; if (mem[2] !== 32'h1122CCDD) begin failures++; $display("FAIL rm_mem_rel got=%h exp=1122ccdd", mem[2]); end
      inst_req = 1'b1; inst_addr = 32'h0;
      #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rm_idle_aok got=%0b exp=1", inst_addr_ok); end
      @(negedge clk);
      inst_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      inst_req = 1'b0; inst_addr = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
      pre_we = 1'b0; pre_a = 16'h0; pre_d = 32'h0;
      preload(16'd0, 32'h0);
      preload(16'd1, 32'h02800c0c);
      preload(16'd2, 32'h11223344);
      preload(16'd4, 32'h0);
      test_reset();
      test_arbitration();
      test_inst_read();
      test_partial_write();
      test_full_write();
      test_reset_mid_merge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
